// File: rtl/prod_accum_feeder.sv
// prod_accum_feeder: deserialises a valid/ready word stream into a zero-padded
// lane bus for the product-accumulation tree, fires a one-cycle compute enable
// with the latched op select, then returns the tree result (or a timeout error)
// on a valid/ready output.
module prod_accum_feeder #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_LANES      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_vld,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_last,
  input  logic                             op_sel_cfg,
  output logic                             in_rdy,
  output logic [NUM_LANES*DATA_WIDTH-1:0]  lane_data,
  output logic                             comp_en,
  output logic                             data_in_op_sel,
  input  logic [DATA_WIDTH-1:0]            acc_data,
  input  logic                             acc_vld,
  output logic [DATA_WIDTH-1:0]            res_data,
  output logic                             res_err,
  output logic                             res_vld,
  input  logic                             res_rdy,
  output logic                             busy
);

  localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  lane_q [NUM_LANES];
  logic [DATA_WIDTH-1:0]  lane_d [NUM_LANES];
  logic                   op_q, op_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   in_rdy_q, in_rdy_d;
  logic                   comp_en_q, comp_en_d;
  logic                   op_sel_q, op_sel_d;
  logic [DATA_WIDTH-1:0]  res_data_q, res_data_d;
  logic                   res_err_q, res_err_d;
  logic                   res_vld_q, res_vld_d;

  // Next-state, datapath and registered-output computation.
  // Outputs are registered from state_d so they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    op_d       = op_q;
    timer_d    = timer_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;

    case (state_q)
      S_FILL: begin
        if (in_vld && in_rdy_q) begin
          for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (CNT_W'(k) == cnt_q) lane_d[k] = in_data;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) op_d = op_sel_cfg;
          if (in_last || (cnt_q == CNT_W'(NUM_LANES - 1))) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (acc_vld) begin
          res_data_d = acc_data;
          res_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (res_rdy) begin
          cnt_d = '0;
          for (int unsigned k = 0; k < NUM_LANES; k++) lane_d[k] = '0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase

    in_rdy_d  = (state_d == S_FILL);
    comp_en_d = (state_d == S_ISSUE);
    res_vld_d = (state_d == S_RESP);
    // op_d, not op_q, so a one-word vector presents its own op select at ISSUE
    op_sel_d  = (state_d != S_FILL) ? op_d : 1'b0;
  end

  // State, lane storage and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      cnt_q      <= '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) lane_q[k] <= '0;
      op_q       <= 1'b0;
      timer_q    <= '0;
      in_rdy_q   <= 1'b0;
      comp_en_q  <= 1'b0;
      op_sel_q   <= 1'b0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      res_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      op_q       <= op_d;
      timer_q    <= timer_d;
      in_rdy_q   <= in_rdy_d;
      comp_en_q  <= comp_en_d;
      op_sel_q   <= op_sel_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      res_vld_q  <= res_vld_d;
    end
  end

  // Lane bus: lanes at or beyond the fill count read as zero (zero padding).
  always_comb begin
    lane_data = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (CNT_W'(k) < cnt_q) lane_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[k];
    end
  end

  assign in_rdy         = in_rdy_q;
  assign comp_en        = comp_en_q;
  assign data_in_op_sel = op_sel_q;
  assign res_data       = res_data_q;
  assign res_err        = res_err_q;
  assign res_vld        = res_vld_q;
  assign busy           = (state_q != S_FILL) || (cnt_q != '0);

endmodule
